memory_xbar: RTL and testbench
==============================

Name: memory_xbar

Overview:
- Parametrised single-master, N-slave memory interconnect between the arbiter's memory port and the peripherals (bram, clint, print, rom, future slaves).
- Replaces the hand-written combinational decode. Adds:
  - a configurable address map;
  - a registered request and response path;
  - a per-transaction ownership state machine;
  - an error response for unmapped addresses;
  - a watchdog timeout on slaves that never respond.

Parameters:
- NSLAVE, 4, number of slave ports (1..16).
- SLV_BASE, {32'h0,32'h2000000,32'h1000000,32'h0}, packed NSLAVE*32 vector of slave base addresses, slave 0 in bits [31:0].
- SLV_TOP, {32'h0,32'h200C000,32'h1000004,32'h0}, packed NSLAVE*32 vector of exclusive top addresses.
- TIMEOUT, 255, number of cycles to wait for slave ready before an error response; 8-bit counter width is sufficient for the default.
- HOST_SLAVE, 0, slave index for the host-address override (optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- memory_valid  in  1  one-cycle request pulse from master
- memory_instr  in  1  instruction-fetch flag
- memory_addr  in  32  request address
- memory_wdata  in  32  write data
- memory_wstrb  in  4  byte strobes; 0 means read
- memory_rdata  out  32  response data
- memory_ready  out  1  one-cycle response pulse
- memory_error  out  1  valid with memory_ready; 1 means unmapped address or timeout
- slv_valid  out  NSLAVE  one-hot request pulse
- slv_instr  out  1  registered instr, shared by all slaves
- slv_addr  out  32  registered address minus selected base, shared
- slv_wdata  out  32  registered wdata, shared
- slv_wstrb  out  4  registered wstrb, shared
- slv_rdata  in  NSLAVE*32  per-slave read data
- slv_ready  in  NSLAVE  per-slave ready
- host_addr  in  32  host address; present only with HOST_ADDR_EN

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: all outputs 0, state IDLE, timeout counter 0, selected index 0.
  - Reset mid-transaction aborts the transaction. No response is issued after reset release.
- Decode:
  - Slave i hits when SLV_BASE[i] <= addr < SLV_TOP[i] (unsigned).
  - On overlap the lowest index wins.
  - A slave with base == top never hits.
- State IDLE:
  - On memory_valid, latch instr, addr−base, wdata, wstrb and the hit index.
  - If a slave hits, go to ISSUE; otherwise go to ERR.
- State ISSUE (one cycle):
  - slv_valid[sel]=1, all other slv_valid bits 0. Shared request buses hold the latched values.
  - Counter cleared. Go to WAIT.
- State WAIT:
  - Only slv_ready[sel] is observed; ready from non-selected slaves is ignored.
  - On slv_ready[sel]: capture slv_rdata[sel], go to RESP with error=0.
  - Otherwise increment the counter. When it reaches TIMEOUT, go to RESP with error=1 and rdata=0.
  - Ready arriving in the same cycle the counter hits TIMEOUT counts as success.
- State ERR (one cycle): go to RESP with error=1, rdata=0.
- State RESP (one cycle): memory_ready=1, memory_rdata and memory_error registered. Return to IDLE.
- Latency:
  - Hit with a slave that answers in k cycles after its valid: memory_ready arrives k+2 cycles after memory_valid.
  - Unmapped address: memory_ready arrives 2 cycles after memory_valid.
- Master protocol:
  - memory_valid outside IDLE is a protocol violation. It is ignored; no state change and no response.
  - memory_valid in RESP is also ignored; the master must wait for memory_ready.
- memory_rdata holds its last value between responses. memory_ready and slv_valid are strictly single-cycle pulses.
- slv_addr is 32-bit wrap-around subtraction, with no saturation.

Optional Feature:
- Macro: HOST_ADDR_EN.
- When defined:
  - The host_addr port exists.
  - An exact match memory_addr == host_addr has top priority and routes to HOST_SLAVE with slv_addr = host_addr (no base subtraction).
  - host_addr == 0 disables the override.
- When undefined: the port is absent and decode is range-only.

Test Plan:
- Read hit, slave 1, map {0x0..0x100000}: valid at 0x1000 on cycle 0, slave 1 ready 1 cycle after its valid with rdata 0xDEADBEEF → slv_valid=4'b0010 on cycle 1, slv_addr=0x1000, memory_ready on cycle 3 with rdata 0xDEADBEEF, error 0.
- Write to clint slave (base 0x2000000), addr 0x2004000, wstrb 4'hF, wdata 0x12345678 → slv_addr=0x4000, slv_wstrb=4'hF, ready with error 0.
- Unmapped address 0x30000000 → no slv_valid pulse; memory_ready with error=1, rdata=0 exactly 2 cycles after valid.
- TIMEOUT=8, addressed slave never asserts ready → memory_ready with error=1 after counter reaches 8; ready pulsed by a non-selected slave during WAIT is ignored.
- Reset asserted in WAIT, then released → all outputs 0, no late memory_ready; next request at 0x1000 completes normally.
- With HOST_ADDR_EN, host_addr=0x80001000 (outside every range), HOST_SLAVE=0 → slv_valid[0] pulses, slv_addr=0x80001000; with host_addr=0 the same access returns error=1.

Source files
------------

// File: rtl/memory_xbar_if.sv
// -----------------------------------------------------------------------------
// memory_xbar_if
// Bundles both sides of the memory interconnect: the single master's memory
// port (memory_*) and the shared/one-hot request buses towards the slaves
// (slv_*).
//
// Modports:
//   slave  - the interconnect's view. It is the slave of the master's memory
//            port and it drives the request buses towards the peripherals.
//   master - the environment's view: the master driving requests and the
//            peripherals answering them.
//
// Signals:
//   memory_valid/instr/addr/wdata/wstrb   request from master
//   memory_rdata/ready/error              response to master
//   slv_valid (one-hot), slv_instr/addr/wdata/wstrb (shared)
//   slv_rdata (NSLAVE*32), slv_ready (NSLAVE) from the peripherals
// -----------------------------------------------------------------------------
interface memory_xbar_if #(
   parameter int NSLAVE = 4
);
   logic                    memory_valid;
   logic                    memory_instr;
   logic [31:0]             memory_addr;
   logic [31:0]             memory_wdata;
   logic [3:0]              memory_wstrb;
   logic [31:0]             memory_rdata;
   logic                    memory_ready;
   logic                    memory_error;

   logic [NSLAVE-1:0]       slv_valid;
   logic                    slv_instr;
   logic [31:0]             slv_addr;
   logic [31:0]             slv_wdata;
   logic [3:0]              slv_wstrb;
   logic [NSLAVE*32-1:0]    slv_rdata;
   logic [NSLAVE-1:0]       slv_ready;

   modport slave (
      input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
      output memory_rdata, memory_ready, memory_error,
      output slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
      input  slv_rdata, slv_ready
   );

   modport master (
      output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
      input  memory_rdata, memory_ready, memory_error,
      input  slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
      output slv_rdata, slv_ready
   );
endinterface

// File: rtl/memory_xbar.sv
// -----------------------------------------------------------------------------
// memory_xbar
// Single-master, NSLAVE-slave memory interconnect with a parameterised address
// map, registered request/response paths, a per-transaction ownership FSM,
// an error response for unmapped addresses and a watchdog on silent slaves.
//
// Ports:
//   clock      system clock
//   reset      asynchronous active-low reset
//   host_addr  host-address override (only when HOST_ADDR_EN is defined)
//   bus        memory_xbar_if.slave (master memory port + slave buses)
//
// Optional feature macro: HOST_ADDR_EN
//   When defined, an exact match memory_addr == host_addr (host_addr != 0)
//   wins over the range decode and routes to HOST_SLAVE with the untranslated
//   address. When undefined, decode is range-only and host_addr is absent.
// -----------------------------------------------------------------------------
module memory_xbar #(
   parameter int                   NSLAVE     = 4,
   parameter logic [NSLAVE*32-1:0] SLV_BASE   = {32'h0, 32'h2000000, 32'h1000000, 32'h0},
   parameter logic [NSLAVE*32-1:0] SLV_TOP    = {32'h0, 32'h200C000, 32'h1000004, 32'h0},
   parameter int                   TIMEOUT    = 255,
   parameter int                   HOST_SLAVE = 0
) (
   input logic          clock,
   input logic          reset,
`ifdef HOST_ADDR_EN
   input logic [31:0]   host_addr,
`endif
   memory_xbar_if.slave bus
);

   localparam int IW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   // The watchdog fires when the counter would reach TIMEOUT, so a ready in
   // that same cycle is still taken as a success.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ERR, RESP} state_t;

   state_t             r_state;
   logic [IW-1:0]      r_sel;
   logic [CW-1:0]      r_cnt;
   logic [NSLAVE-1:0]  r_slvValid;
   logic               r_instr;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [3:0]         r_wstrb;
   logic [31:0]        r_rdata;
   logic               r_ready;
   logic               r_error;

   logic               w_hit;
   logic [IW-1:0]      w_idx;
   logic [31:0]        w_slvAddr;
   logic               w_selReady;
   logic [31:0]        w_selRdata;

`ifndef HOST_ADDR_EN
   logic [IW-1:0]      w_unusedHostIdx;
   assign w_unusedHostIdx = IW'(HOST_SLAVE);
`endif

   // Address decode. Walking from the highest index down lets the lowest
   // matching slave overwrite the others, so overlaps resolve to the lowest
   // index. A window with base >= top is empty and never matches.
   always_comb begin
      w_hit     = 1'b0;
      w_idx     = '0;
      w_slvAddr = bus.memory_addr;
      for (int i = NSLAVE - 1; i >= 0; i--) begin
         if ((SLV_BASE[i*32 +: 32] < SLV_TOP[i*32 +: 32]) &&
             (bus.memory_addr >= SLV_BASE[i*32 +: 32]) &&
             (bus.memory_addr <  SLV_TOP[i*32 +: 32])) begin
            w_hit     = 1'b1;
            w_idx     = IW'(i);
            w_slvAddr = bus.memory_addr - SLV_BASE[i*32 +: 32];
         end
      end
`ifdef HOST_ADDR_EN
      if ((host_addr != 32'h0) && (bus.memory_addr == host_addr)) begin
         w_hit     = 1'b1;
         w_idx     = IW'(HOST_SLAVE);
         w_slvAddr = host_addr;
      end
`endif
   end

   // Response mux: only the slave that owns the transaction is listened to,
   // so stray ready pulses from other slaves cannot complete it.
   always_comb begin
      w_selReady = 1'b0;
      w_selRdata = '0;
      for (int i = 0; i < NSLAVE; i++) begin
         if (r_sel == IW'(i)) begin
            w_selReady = bus.slv_ready[i];
            w_selRdata = bus.slv_rdata[i*32 +: 32];
         end
      end
   end

   // Ownership FSM. All outputs are registered here; slv_valid and
   // memory_ready default low every cycle so they can only ever be
   // single-cycle pulses. Requests arriving outside IDLE are dropped.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_sel      <= '0;
         r_cnt      <= '0;
         r_slvValid <= '0;
         r_instr    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_rdata    <= '0;
         r_ready    <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_slvValid <= '0;
         r_ready    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.memory_valid) begin
                  r_instr <= bus.memory_instr;
                  r_addr  <= w_slvAddr;
                  r_wdata <= bus.memory_wdata;
                  r_wstrb <= bus.memory_wstrb;
                  r_sel   <= w_idx;
                  if (w_hit) begin
                     r_slvValid <= NSLAVE'(1) << w_idx;
                     r_state    <= ISSUE;
                  end else begin
                     r_state    <= ERR;
                  end
               end
            end
            ISSUE: begin
               r_cnt   <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (w_selReady) begin
                  r_rdata <= w_selRdata;
                  r_error <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= RESP;
               end else if (r_cnt == CNT_LAST) begin
                  r_rdata <= '0;
                  r_error <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ERR: begin
               r_rdata <= '0;
               r_error <= 1'b1;
               r_ready <= 1'b1;
               r_state <= RESP;
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.slv_valid    = r_slvValid;
   assign bus.slv_instr    = r_instr;
   assign bus.slv_addr     = r_addr;
   assign bus.slv_wdata    = r_wdata;
   assign bus.slv_wstrb    = r_wstrb;
   assign bus.memory_rdata = r_rdata;
   assign bus.memory_ready = r_ready;
   assign bus.memory_error = r_error;

endmodule

// File: tb/tb_memory_xbar.sv
// -----------------------------------------------------------------------------
// tb_memory_xbar
// Directed, table-driven bench for memory_xbar. Map used here (5 slaves):
//   s0 0x40000000..0x40000100   s1 0x00000000..0x00100000
//   s2 0x02000000..0x0200C000   s3 0x00000000..0x00200000 (overlaps s1)
//   s4 0x30000000..0x30000000   (empty window)
// TIMEOUT = 8, HOST_SLAVE = 0. Define HOST_ADDR_EN to add the override vectors.
// -----------------------------------------------------------------------------
module tb_memory_xbar;

   localparam int NSLAVE = 5;
   localparam int TIMEOUT = 8;
   localparam logic [NSLAVE*32-1:0] BASES =
      {32'h30000000, 32'h00000000, 32'h02000000, 32'h00000000, 32'h40000000};
   localparam logic [NSLAVE*32-1:0] TOPS =
      {32'h30000000, 32'h00200000, 32'h0200C000, 32'h00100000, 32'h40000100};

   typedef struct {
      string             name;
      logic              instr;
      logic [31:0]       addr;
      logic [31:0]       wdata;
      logic [3:0]        wstrb;
      logic [31:0]       hostAddr;
      int                lat;
      logic [NSLAVE-1:0] stray;
      int                intrude;
      logic [NSLAVE-1:0] expValid;
      logic [31:0]       expSlvAddr;
      int                expLat;
      logic [31:0]       expRdata;
      logic              expErr;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
`ifdef HOST_ADDR_EN
   logic [31:0] hostAddr = 32'h0;
`endif

   memory_xbar_if #(.NSLAVE(NSLAVE)) bus ();

   logic [NSLAVE-1:0]    respReady  = '0;
   logic [NSLAVE-1:0]    strayReady = '0;
   logic [NSLAVE*32-1:0] respRdata  = '0;
   int                   curLat     = 0;
   int                   pendCnt [NSLAVE];
   logic [31:0]          slvData [NSLAVE];

   int nApplied     = 0;
   int nMiscompares = 0;
   vec_t vecs[$];

   assign bus.slv_ready = respReady | strayReady;
   assign bus.slv_rdata = respRdata;

   memory_xbar #(
      .NSLAVE(NSLAVE), .SLV_BASE(BASES), .SLV_TOP(TOPS),
      .TIMEOUT(TIMEOUT), .HOST_SLAVE(0)
   ) dut (
      .clock(clock),
      .reset(reset),
`ifdef HOST_ADDR_EN
      .host_addr(hostAddr),
`endif
      .bus(bus)
   );

   // 10 ns clock
   always #5 clock = ~clock;

   // Behavioural slaves: each one answers curLat cycles after its valid
   // with a one-cycle ready and its own data word; curLat == 0 means silent.
   // Outside the ready cycle the data bus carries junk so a capture at the
   // wrong moment shows up.
   always @(negedge clock) begin
      for (int i = 0; i < NSLAVE; i++) begin
         respReady[i] = 1'b0;
         respRdata[i*32 +: 32] = 32'hBAD00000 | 32'(i);
         if (pendCnt[i] > 0) begin
            pendCnt[i] = pendCnt[i] - 1;
            if (pendCnt[i] == 0) begin
               respReady[i] = 1'b1;
               respRdata[i*32 +: 32] = slvData[i];
            end
         end
         if (bus.slv_valid[i]) pendCnt[i] = curLat;
      end
   end

   // Single comparison point: counts every check and reports misses.
   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nApplied++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Everything the block drives must be zero while held in reset.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".memory_ready"}, 32'(bus.memory_ready), 32'h0);
      checkOutput({tag, ".memory_rdata"}, bus.memory_rdata, 32'h0);
      checkOutput({tag, ".memory_error"}, 32'(bus.memory_error), 32'h0);
      checkOutput({tag, ".slv_valid"}, 32'(bus.slv_valid), 32'h0);
      checkOutput({tag, ".slv_addr"}, bus.slv_addr, 32'h0);
      checkOutput({tag, ".slv_wdata"}, bus.slv_wdata, 32'h0);
      checkOutput({tag, ".slv_wstrb"}, 32'(bus.slv_wstrb), 32'h0);
      checkOutput({tag, ".slv_instr"}, 32'(bus.slv_instr), 32'h0);
   endtask

   task automatic addVec(input string n, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ha,
                         input int lat, input logic [NSLAVE-1:0] st, input int intr,
                         input logic [NSLAVE-1:0] ev, input logic [31:0] esa, input int el,
                         input logic [31:0] erd, input logic ee);
      vec_t v;
      v.name = n; v.instr = ins; v.addr = a; v.wdata = wd; v.wstrb = ws;
      v.hostAddr = ha; v.lat = lat; v.stray = st; v.intrude = intr;
      v.expValid = ev; v.expSlvAddr = esa; v.expLat = el; v.expRdata = erd; v.expErr = ee;
      vecs.push_back(v);
   endtask

   // Launch one request (cycle 0), watch the buses for a bounded window and
   // compare what was seen against the vector's expectations. Cycle c is the
   // state right after the c-th rising edge following the request.
   task automatic applyStimulus(input vec_t v);
      int readyCyc = -1;
      int readyCnt = 0;
      int pulseCyc = -1;
      int pulseCnt = 0;
      logic [NSLAVE-1:0] seenValid = '0;
      logic [31:0] seenAddr = '0;
      logic [31:0] seenWdata = '0;
      logic [3:0]  seenWstrb = '0;
      logic        seenInstr = 1'b0;
      logic [31:0] gotRdata = '0;
      logic        gotErr = 1'b0;
      logic [31:0] holdRdata = '0;
      curLat = v.lat;
      @(posedge clock); #1;
`ifdef HOST_ADDR_EN
      hostAddr = v.hostAddr;
`endif
      bus.memory_valid = 1'b1;
      bus.memory_instr = v.instr;
      bus.memory_addr  = v.addr;
      bus.memory_wdata = v.wdata;
      bus.memory_wstrb = v.wstrb;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock); #1;
         if (bus.slv_valid != '0) begin
            pulseCnt++;
            if (pulseCyc < 0) begin
               pulseCyc  = c;
               seenValid = bus.slv_valid;
               seenAddr  = bus.slv_addr;
               seenWdata = bus.slv_wdata;
               seenWstrb = bus.slv_wstrb;
               seenInstr = bus.slv_instr;
            end
         end
         if (bus.memory_ready) begin
            readyCnt++;
            if (readyCyc < 0) begin
               readyCyc = c;
               gotRdata = bus.memory_rdata;
               gotErr   = bus.memory_error;
            end
         end
         if (readyCyc > 0 && c == readyCyc + 1) holdRdata = bus.memory_rdata;
         bus.memory_valid = (c == v.intrude);
         if (c == v.intrude) bus.memory_addr = 32'h00001000;
         strayReady = (c == 4) ? v.stray : '0;
         if (readyCyc > 0 && c >= readyCyc + 4) break;
      end
      bus.memory_valid = 1'b0;
      strayReady = '0;

      checkOutput({v.name, ".valid_pulses"}, 32'(pulseCnt), (v.expValid != '0) ? 32'h1 : 32'h0);
      if (v.expValid != '0) begin
         checkOutput({v.name, ".valid_cycle"}, 32'(pulseCyc), 32'h1);
         checkOutput({v.name, ".slv_valid"}, 32'(seenValid), 32'(v.expValid));
         checkOutput({v.name, ".slv_addr"}, seenAddr, v.expSlvAddr);
         checkOutput({v.name, ".slv_wdata"}, seenWdata, v.wdata);
         checkOutput({v.name, ".slv_wstrb"}, 32'(seenWstrb), 32'(v.wstrb));
         checkOutput({v.name, ".slv_instr"}, 32'(seenInstr), 32'(v.instr));
      end
      checkOutput({v.name, ".ready_pulses"}, 32'(readyCnt), 32'h1);
      checkOutput({v.name, ".latency"}, 32'(readyCyc), 32'(v.expLat));
      checkOutput({v.name, ".rdata"}, gotRdata, v.expRdata);
      checkOutput({v.name, ".error"}, 32'(gotErr), 32'(v.expErr));
      checkOutput({v.name, ".rdata_hold"}, holdRdata, v.expRdata);
   endtask

   initial begin
      int lateReady;
      int latePulse;
      for (int i = 0; i < NSLAVE; i++) pendCnt[i] = 0;
      slvData[0] = 32'hA0A0A0A0;
      slvData[1] = 32'hDEADBEEF;
      slvData[2] = 32'hC1C1C1C1;
      slvData[3] = 32'h33333333;
      slvData[4] = 32'h44444444;
      bus.memory_valid = 1'b0;
      bus.memory_instr = 1'b0;
      bus.memory_addr  = '0;
      bus.memory_wdata = '0;
      bus.memory_wstrb = '0;

      //      name            ins   addr          wdata         wstrb host         lat stray     intr expValid  expSlvAddr    lat rdata          err
      addVec("rd_s1",         1'b0, 32'h00001000, 32'h00000000, 4'h0, 32'h0,         1, 5'b00000, 0, 5'b00010, 32'h00001000,  3, 32'hDEADBEEF, 1'b0);
      addVec("wr_clint",      1'b0, 32'h02004000, 32'h12345678, 4'hF, 32'h0,         2, 5'b00000, 0, 5'b00100, 32'h00004000,  4, 32'hC1C1C1C1, 1'b0);
      addVec("unmapped",      1'b0, 32'h30000000, 32'h00000000, 4'h0, 32'h0,         1, 5'b00000, 0, 5'b00000, 32'h0,         2, 32'h00000000, 1'b1);
      addVec("overlap_s3",    1'b0, 32'h00150000, 32'hAABBCCDD, 4'h3, 32'h0,         3, 5'b00000, 0, 5'b01000, 32'h00150000,  5, 32'h33333333, 1'b0);
      addVec("s1_last",       1'b0, 32'h000FFFFF, 32'h00000000, 4'h0, 32'h0,         1, 5'b00000, 0, 5'b00010, 32'h000FFFFF,  3, 32'hDEADBEEF, 1'b0);
      addVec("s1_top_excl",   1'b0, 32'h00100000, 32'h00000000, 4'h0, 32'h0,         1, 5'b00000, 0, 5'b01000, 32'h00100000,  3, 32'h33333333, 1'b0);
      addVec("s3_top_excl",   1'b0, 32'h00200000, 32'h00000000, 4'h0, 32'h0,         1, 5'b00000, 0, 5'b00000, 32'h0,         2, 32'h00000000, 1'b1);
      addVec("s0_fetch",      1'b1, 32'h40000000, 32'h00000000, 4'h0, 32'h0,         1, 5'b00000, 0, 5'b00001, 32'h00000000,  3, 32'hA0A0A0A0, 1'b0);
      addVec("s0_last",       1'b0, 32'h400000FF, 32'h0000BEEF, 4'hC, 32'h0,         4, 5'b00000, 0, 5'b00001, 32'h000000FF,  6, 32'hA0A0A0A0, 1'b0);
      addVec("s0_top_excl",   1'b0, 32'h40000100, 32'h00000000, 4'h0, 32'h0,         1, 5'b00000, 0, 5'b00000, 32'h0,         2, 32'h00000000, 1'b1);
      addVec("below_s2",      1'b0, 32'h01FFFFFF, 32'h00000000, 4'h0, 32'h0,         1, 5'b00000, 0, 5'b00000, 32'h0,         2, 32'h00000000, 1'b1);
      addVec("timeout_stray", 1'b0, 32'h02000010, 32'h00000000, 4'h0, 32'h0,         0, 5'b01010, 0, 5'b00100, 32'h00000010, 10, 32'h00000000, 1'b1);
      addVec("ready_at_lim",  1'b0, 32'h02000020, 32'h00000000, 4'h0, 32'h0,         8, 5'b00000, 0, 5'b00100, 32'h00000020, 10, 32'hC1C1C1C1, 1'b0);
      addVec("ready_late",    1'b0, 32'h02000030, 32'h00000000, 4'h0, 32'h0,         9, 5'b00000, 0, 5'b00100, 32'h00000030, 10, 32'h00000000, 1'b1);
      addVec("intrude_wait",  1'b0, 32'h00001000, 32'h00000000, 4'h0, 32'h0,         3, 5'b00000, 2, 5'b00010, 32'h00001000,  5, 32'hDEADBEEF, 1'b0);
      addVec("intrude_resp",  1'b0, 32'h00001000, 32'h00000000, 4'h0, 32'h0,         1, 5'b00000, 3, 5'b00010, 32'h00001000,  3, 32'hDEADBEEF, 1'b0);
`ifdef HOST_ADDR_EN
      addVec("host_hit",      1'b0, 32'h80001000, 32'h00000000, 4'h0, 32'h80001000,  1, 5'b00000, 0, 5'b00001, 32'h80001000,  3, 32'hA0A0A0A0, 1'b0);
      addVec("host_off",      1'b0, 32'h80001000, 32'h00000000, 4'h0, 32'h00000000,  1, 5'b00000, 0, 5'b00000, 32'h0,         2, 32'h00000000, 1'b1);
      addVec("host_prio",     1'b0, 32'h00001000, 32'h00000000, 4'h0, 32'h00001000,  1, 5'b00000, 0, 5'b00001, 32'h00001000,  3, 32'hA0A0A0A0, 1'b0);
      addVec("host_nomatch",  1'b0, 32'h00001000, 32'h00000000, 4'h0, 32'h80001000,  1, 5'b00000, 0, 5'b00010, 32'h00001000,  3, 32'hDEADBEEF, 1'b0);
`endif

      // Power-up reset state
      repeat (3) @(posedge clock);
      #1;
      checkResetOutputs("por");
      reset = 1'b1;

      foreach (vecs[k]) applyStimulus(vecs[k]);

      // Reset while the owning slave is silent in WAIT: everything clears and
      // no response may leak out after release.
      curLat = 0;
      @(posedge clock); #1;
      bus.memory_valid = 1'b1;
      bus.memory_instr = 1'b1;
      bus.memory_addr  = 32'h02000010;
      bus.memory_wdata = 32'h55555555;
      bus.memory_wstrb = 4'hF;
      @(posedge clock); #1;
      bus.memory_valid = 1'b0;
      repeat (3) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      checkResetOutputs("rst_wait");
      @(posedge clock); #1;
      reset = 1'b1;
      lateReady = 0;
      latePulse = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clock); #1;
         if (bus.memory_ready) lateReady++;
         if (bus.slv_valid != '0) latePulse++;
      end
      checkOutput("rst_wait.late_ready", 32'(lateReady), 32'h0);
      checkOutput("rst_wait.late_valid", 32'(latePulse), 32'h0);
      applyStimulus(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
      $finish;
   end

endmodule
